// File: rtl/kore_pkg.sv
// Shared field positions, opcode constants and FSM state type for the op-issue slice.
package kore_pkg;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 7;
  localparam int RD_LSB   = 7;
  localparam int RD_W     = 5;
  localparam int BC_LSB   = 12;
  localparam int BC_W     = 3;
  localparam int RS1_LSB  = 15;
  localparam int RS1_W    = 5;
  localparam int RS0_LSB  = 20;
  localparam int RS0_W    = 5;
  localparam int FUNC_LSB = 25;

  localparam logic [2:0] OP_BC_WAIT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/kore_sync_fifo.sv
// Synchronous FIFO with registered storage; the head word is readable once it is stored.
module kore_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kore_opissue.sv
// Instruction-issue engine: queues words, decodes fields and strobes or holds a per-channel opflag.
module kore_opissue
  import kore_pkg::*;
#(
  parameter int IW      = 33,
  parameter int DEPTH   = 4,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          pcdata_in,
  input  logic [NCH-1:0]         eop,
  input  logic                   err_clr,
  output logic [6:0]             opcode,
  output logic [4:0]             pcdata_rd,
  output logic [2:0]             pcdata_bc,
  output logic [4:0]             pcdata_rs1,
  output logic [4:0]             pcdata_rs0,
  output logic [IW-26:0]         pc_sel,
  output logic [NCH-1:0]         opflag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [NCH-1:0]  opflag_q, opflag_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      err_q, err_d;

  logic [IW-1:0]   head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [CW-1:0]   head_ch;
  logic            head_bad;
  logic            head_wait;
  logic [NCH-1:0]  head_onehot;
  logic            eop_hit;
  logic            timer_hit;

  assign in_ready = !full;
  assign push     = in_valid && !full;

  kore_sync_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (pcdata_in),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign head_ch   = head[FUNC_LSB +: CW];
  assign head_bad  = ({1'b0, head_ch} >= (CW+1)'(NCH));
  assign head_wait = (head[BC_LSB +: BC_W] == OP_BC_WAIT);

  always_comb begin
    head_onehot = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      head_onehot[i] = (head_ch == CW'(i));
    end
  end

  // While BUSY opflag is one-hot on the latched channel, so it doubles as the eop mask.
  assign eop_hit   = |(eop & opflag_q);
  assign timer_hit = (TIMEOUT != 0) && (timer_q == TMAX);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opflag_d = opflag_q;
    timer_d  = timer_q;
    err_d    = err_clr ? '0 : err_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        opflag_d = '0;
        if (!empty) begin
          pop  = 1'b1;
          ir_d = head;
          if (head_bad) begin
            err_d[1] = 1'b1;
          end else if (head_wait) begin
            opflag_d = head_onehot;
            state_d  = BUSY;
            timer_d  = '0;
          end else begin
            opflag_d = head_onehot;
          end
        end
      end
      BUSY: begin
        timer_d = timer_q + 1'b1;
        if (eop_hit) begin
          opflag_d = '0;
          state_d  = IDLE;
        end else if (timer_hit) begin
          err_d[0] = 1'b1;
          opflag_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      opflag_q <= '0;
      timer_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      opflag_q <= opflag_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign opcode     = ir_q[OPC_LSB +: OPC_W];
  assign pcdata_rd  = ir_q[RD_LSB +: RD_W];
  assign pcdata_bc  = ir_q[BC_LSB +: BC_W];
  assign pcdata_rs1 = ir_q[RS1_LSB +: RS1_W];
  assign pcdata_rs0 = ir_q[RS0_LSB +: RS0_W];
  assign pc_sel     = ir_q[IW-1:FUNC_LSB];
  assign opflag     = opflag_q;
  assign busy       = (state_q == BUSY);
  assign err        = err_q;

endmodule

// File: tb/tb_kore_opissue.sv
// Directed bench for kore_opissue (NCH=3, TIMEOUT=8) against a queue-based reference model.
module tb_kore_opissue;

  localparam int IW      = 33;
  localparam int DEPTH   = 4;
  localparam int NCH     = 3;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] pcdata_in = '0;
  logic [2:0]  eop = '0;
  logic        err_clr = 1'b0;
  logic [6:0]  opcode;
  logic [4:0]  pcdata_rd;
  logic [2:0]  pcdata_bc;
  logic [4:0]  pcdata_rs1;
  logic [4:0]  pcdata_rs0;
  logic [7:0]  pc_sel;
  logic [2:0]  opflag;
  logic        busy;
  logic [2:0]  count;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  kore_opissue #(
    .IW      (IW),
    .DEPTH   (DEPTH),
    .NCH     (NCH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pcdata_in  (pcdata_in),
    .eop        (eop),
    .err_clr    (err_clr),
    .opcode     (opcode),
    .pcdata_rd  (pcdata_rd),
    .pcdata_bc  (pcdata_bc),
    .pcdata_rs1 (pcdata_rs1),
    .pcdata_rs0 (pcdata_rs0),
    .pc_sel     (pc_sel),
    .opflag     (opflag),
    .busy       (busy),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word layout: func[32:25] rs0[24:20] rs1[19:15] bc[14:12] rd[11:7] opcode[6:0]
  function automatic logic [32:0] mkw(input int func, input int bc, input int tag);
    return {8'(func), 5'(tag), 5'(tag + 1), 3'(bc), 5'(tag + 2), 7'(tag * 3)};
  endfunction

  // Reference model: queue of pending words, what was last issued, and how long we have waited.
  logic [32:0] mq[$];
  logic [32:0] m_word = '0;
  logic [2:0]  m_flag = '0;
  bit          m_wait = 1'b0;
  int          m_waited = 0;
  logic [1:0]  m_err = '0;

  initial begin
    logic [32:0] w;
    logic [32:0] pw;
    bit          take;
    int          ch;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_word = '0; m_flag = '0; m_wait = 1'b0; m_waited = 0; m_err = '0;
      end else begin
        take = in_valid && (mq.size() < DEPTH);
        pw   = pcdata_in;
        if (err_clr) m_err = '0;
        if (!m_wait) begin
          m_flag = '0;
          if (mq.size() > 0) begin
            w = mq.pop_front();
            m_word = w;
            ch = int'(w[32:25]) % 4;
            if (ch >= NCH) m_err[1] = 1'b1;
            else begin
              m_flag = 3'(1 << ch);
              if (w[14:12] == 3'b111) begin
                m_wait = 1'b1;
                m_waited = 0;
              end
            end
          end
        end else begin
          m_waited++;
          if ((eop & m_flag) != 3'b000) begin
            m_wait = 1'b0; m_flag = '0;
          end else if (TIMEOUT != 0 && m_waited >= TIMEOUT) begin
            m_err[0] = 1'b1; m_wait = 1'b0; m_flag = '0;
          end
        end
        if (take) mq.push_back(pw);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("opflag",  opflag,     m_flag);
      chk("busy",    busy,       m_wait);
      chk("count",   count,      mq.size());
      chk("in_ready", in_ready,  mq.size() < DEPTH);
      chk("err",     err,        m_err);
      chk("opcode",  opcode,     m_word[6:0]);
      chk("rd",      pcdata_rd,  m_word[11:7]);
      chk("bc",      pcdata_bc,  m_word[14:12]);
      chk("rs1",     pcdata_rs1, m_word[19:15]);
      chk("rs0",     pcdata_rs0, m_word[24:20]);
      chk("pc_sel",  pc_sel,     m_word[32:25]);
    end
  end

  initial begin
    // Reset held with in_valid high
    in_valid  = 1'b1;
    pcdata_in = mkw(2, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("lit_rst_opflag", opflag, 3'b000);
    chk("lit_rst_count", count, 3'd0);
    chk("lit_rst_ready", in_ready, 1'b1);
    chk("lit_rst_err", err, 2'b00);
    @(negedge clk) rst_n = 1'b1;

    // Fire-and-forget back to back, with push and pop on the same edge
    @(negedge clk) pcdata_in = mkw(0, 1, 2);
    @(posedge clk); #2;
    chk("lit_ff_first", opflag, 3'b100);
    chk("lit_ff_sel", pc_sel, 8'd2);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #2;
    chk("lit_ff_second", opflag, 3'b001);
    chk("lit_ff_busy", busy, 1'b0);

    // Wait op on channel 1; eop during issue edge and on other channels is ignored
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(1, 7, 5); end
    @(negedge clk) begin in_valid = 1'b0; eop = 3'b010; end
    @(negedge clk) eop = 3'b001;
    @(negedge clk) eop = 3'b100;
    @(negedge clk) eop = 3'b000;
    @(posedge clk); #2;
    chk("lit_wait_busy", busy, 1'b1);
    chk("lit_wait_flag", opflag, 3'b010);
    @(negedge clk);
    @(negedge clk) eop = 3'b010;
    @(posedge clk); #2;
    chk("lit_wait_done", busy, 1'b0);
    chk("lit_wait_flag0", opflag, 3'b000);
    chk("lit_wait_err", err, 2'b00);
    @(negedge clk) eop = 3'b000;

    // Timeout after 8 BUSY cycles, then clear
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(2, 7, 9); end
    @(negedge clk) in_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk); #2;
    chk("lit_to_err", err, 2'b01);
    chk("lit_to_busy", busy, 1'b0);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    @(posedge clk); #2;
    chk("lit_clr_err", err, 2'b00);

    // eop on the very cycle the timer expires: eop wins
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(1, 7, 3); end
    @(negedge clk) in_valid = 1'b0;
    repeat (8) @(negedge clk);
    eop = 3'b010;
    @(posedge clk); #2;
    chk("lit_race_err", err, 2'b00);
    chk("lit_race_busy", busy, 1'b0);
    @(negedge clk) eop = 3'b000;

    // Timeout while err_clr is held: set wins
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(0, 7, 4); err_clr = 1'b1; end
    @(negedge clk) in_valid = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #2;
    chk("lit_setwins", err, 2'b01);
    @(negedge clk) err_clr = 1'b0;

    // Out-of-range channel (func=3) dropped; func=4 aliases to channel 0
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(3, 7, 6); end
    @(negedge clk) pcdata_in = mkw(4, 0, 7);
    @(posedge clk); #2;
    chk("lit_bad_flag", opflag, 3'b000);
    chk("lit_bad_err", err, 2'b11);
    chk("lit_bad_sel", pc_sel, 8'd3);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #2;
    chk("lit_alias_flag", opflag, 3'b001);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;

    // Fill the queue while BUSY; fifth word must be ignored
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(0, 7, 10); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) pcdata_in = mkw((k + 1) % 3, 0, 11 + k);
      if (k == 3) begin
        @(posedge clk); #2;
        chk("lit_full_count", count, 3'd4);
        chk("lit_full_ready", in_ready, 1'b0);
      end
    end
    @(negedge clk) begin in_valid = 1'b0; eop = 3'b001; end
    @(posedge clk); #2;
    chk("lit_fill_idle", busy, 1'b0);
    @(negedge clk) eop = 3'b000;
    @(posedge clk); #2;
    chk("lit_drain_flag", opflag, 3'b010);
    chk("lit_drain_rd", pcdata_rd, 5'd13);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of BUSY with words still queued
    @(negedge clk) begin in_valid = 1'b1; pcdata_in = mkw(2, 7, 20); end
    @(negedge clk) pcdata_in = mkw(0, 0, 21);
    @(negedge clk) pcdata_in = mkw(1, 0, 22);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_busy", busy, 1'b0);
    chk("lit_arst_flag", opflag, 3'b000);
    chk("lit_arst_count", count, 3'd0);
    chk("lit_arst_opcode", opcode, 7'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
